// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for show-ahead reads (head word driven combinationally on rdData).
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         wrEn,
  input  logic [DATA_WIDTH-1:0]        wrData,
  input  logic                         rdEn,
  output logic [DATA_WIDTH-1:0]        rdData,
  output logic                         fifoFull,
  output logic                         fifoEmpty,
  output logic                         almostFull,
  output logic                         almostEmpty,
  output logic [$clog2(DEPTH):0]       fillCount,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clrErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_accept_s;
  logic                  wr_accept_s;

  // A write into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign rd_accept_s = rdEn & ~empty_q;
  assign wr_accept_s = wrEn & (~full_q | rd_accept_s);

  // Next-state: pointers, occupancy, flags computed from the next occupancy, sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_accept_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wrEn & ~wr_accept_s) begin
      ovf_d = 1'b1;
    end else if (clrErr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (rdEn & ~rd_accept_s) begin
      udf_d = 1'b1;
    end else if (clrErr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == {CW{1'b0}});
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= wrData;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdData = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Registered read port: holds its value unless a pop is accepted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_accept_s) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rdData = rd_data_q;
`endif

  assign fifoFull    = full_q;
  assign fifoEmpty   = empty_q;
  assign almostFull  = af_q;
  assign almostEmpty = ae_q;
  assign fillCount   = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (standard registered-read build) against a queue model.
module tb_sync_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          wrEn;
  logic [DW-1:0] wrData;
  logic          rdEn;
  logic [DW-1:0] rdData;
  logic          fifoFull, fifoEmpty, almostFull, almostEmpty;
  logic [CW-1:0] fillCount;
  logic          overflow, underflow;
  logic          clrErr;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  bit            m_ovf, m_udf;

  typedef struct {
    bit        wr;
    bit [7:0]  wd;
    bit        rd;
    bit        clr;
    int        exp_cnt;
    bit [7:0]  exp_rd;
    bit        exp_udf;
  } vec_t;

  vec_t vecs[11];

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn), .rdData(rdData),
    .fifoFull(fifoFull), .fifoEmpty(fifoEmpty), .almostFull(almostFull), .almostEmpty(almostEmpty),
    .fillCount(fillCount), .overflow(overflow), .underflow(underflow), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(fillCount), 32'(n));
    chk({tag, ".full"},  32'(fifoFull),  32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(fifoEmpty), 32'(n == 0));
    chk({tag, ".af"},    32'(almostFull),  32'(n >= AF));
    chk({tag, ".ae"},    32'(almostEmpty), 32'(n <= AE));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(underflow), 32'(m_udf));
    chk({tag, ".rdata"}, 32'(rdData),    32'(m_rd));
  endtask

  // One clock: drive, update the model at the edge, check 1 time unit later.
  task automatic cycle(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr, input string tag);
    int  n;
    bit  ra, wa;
    wrEn = wr; wrData = wd; rdEn = rd; clrErr = clr;
    @(posedge clk);
    n  = q.size();
    ra = rd && (n > 0);
    wa = wr && ((n < DEPTH) || ra);
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(wd);
    if (wr && !wa) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && !ra) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    #1;
    check_model(tag);
    wrEn = 1'b0; rdEn = 1'b0; clrErr = 1'b0;
  endtask

  initial begin
    int pw, pr;
    rstN = 1'b0; wrEn = 1'b0; wrData = '0; rdEn = 1'b0; clrErr = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 2, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 3, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'hAA, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hBB, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'hCC, 1'b0};
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 8'hCC, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h5A, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h5A, 1'b0};

    #12 rstN = 1'b1;
    @(posedge clk); #1;
    check_model("reset");

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tcount", i), 32'(fillCount), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d.trdata", i), 32'(rdData),    32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d.tudf", i),   32'(underflow), 32'(vecs[i].exp_udf));
    end

    // Fill to full, watching the threshold crossings, then overflow.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, "fill");
      if (i == AF - 1) chk("af_before", 32'(almostFull), 32'd0);
      if (i == AF)     chk("af_at",     32'(almostFull), 32'd1);
      if (i == DEPTH - 1) chk("full_before", 32'(fifoFull), 32'd0);
    end
    chk("full_at", 32'(fifoFull), 32'd1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, "ovf");
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(fillCount), 32'(DEPTH));
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_ovf");
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop: count pinned, no overflow.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, "fullrw");
      chk("fullrw.cnt", 32'(fillCount), 32'(DEPTH));
      chk("fullrw.ovf", 32'(overflow), 32'd0);
    end
    chk("fullrw.first", 32'(rdData), 32'h14);

    // Drain; model checks order across the wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drain.last", 32'(rdData), 32'h83);

    // Set and clear in the same cycle: the set wins.
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "setwins");
    chk("setwins.udf", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

    // Random traffic with alternating fill/drain bias.
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 50) % 2 == 0) ? 75 : 30;
      pr = ((i / 50) % 2 == 0) ? 30 : 75;
      cycle($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 5, "rand");
    end

    // Asynchronous reset mid-operation.
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "pre_rst");
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "pre_fill");
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre_rd");
    #3 rstN = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    #2 rstN = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "post_rst");
    chk("post_rst.empty", 32'(fifoEmpty), 32'd1);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, "post_wr");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_rd");
    chk("post_rd.data", 32'(rdData), 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
